// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM encoding and response flag layout,
// the latter also used by the UART slave side.
package apb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } apb_state_e;

    localparam int unsigned RSP_ERR_BIT     = 0;
    localparam int unsigned RSP_TIMEOUT_BIT = 1;
    localparam int unsigned RSP_FLAGS_W     = 2;

endpackage

// File: rtl/apb_master_if.sv
// Command/response streams plus the APB bus of the single-outstanding requester.
interface apb_master_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PREADY, PRDATA, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PADDR, PSELx, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PREADY, PRDATA, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PADDR, PSELx, PENABLE, PWRITE, PWDATA
    );

endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: one valid/ready command becomes one
// SETUP/ACCESS transfer, answered on a valid/ready response stream.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_master_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    apb_state_e             state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [RSP_FLAGS_W-1:0] rsp_flags_q, rsp_flags_d;
    logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_flags_d = rsp_flags_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_ready_q && bus.cmd_valid) begin
                    paddr_d   = bus.cmd_addr;
                    pwrite_d  = bus.cmd_write;
                    pwdata_d  = bus.cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = StAccess;
            end
            StAccess: begin
                if (bus.PREADY) begin
                    rsp_rdata_d                  = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
                    rsp_flags_d[RSP_ERR_BIT]     = bus.PSLVERR;
                    rsp_flags_d[RSP_TIMEOUT_BIT] = 1'b0;
                    psel_d                       = 1'b0;
                    penable_d                    = 1'b0;
                    rsp_valid_d                  = 1'b1;
                    state_d                      = StResp;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    rsp_rdata_d                  = '0;
                    rsp_flags_d[RSP_ERR_BIT]     = 1'b1;
                    rsp_flags_d[RSP_TIMEOUT_BIT] = 1'b1;
                    psel_d                       = 1'b0;
                    penable_d                    = 1'b0;
                    rsp_valid_d                  = 1'b1;
                    state_d                      = StResp;
                end else if (cnt_q != '1) begin
                    // saturate rather than wrap when the timeout is disabled
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // registered ready: high exactly while the FSM sits in IDLE
        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_flags_q <= '0;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_flags_q <= rsp_flags_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_flags_q[RSP_ERR_BIT];
    assign bus.rsp_timeout = rsp_flags_q[RSP_TIMEOUT_BIT];
    assign bus.PADDR       = paddr_q;
    assign bus.PSELx       = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomised bench for apb_master: a scripted APB slave plus a transaction-level
// model of latency and response contents.
module tb_apb_master;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    apb_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus_if.master)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err, bus_if.rsp_timeout,
                    bus_if.PADDR, bus_if.PSELx, bus_if.PENABLE, bus_if.PWRITE, bus_if.PWDATA,
                    bus_if.cmd_ready});
    endfunction

    // Starts and ends at a negedge. The slave answers after `waits` not-ready
    // ACCESS cycles; the response is back-pressured for `hold` cycles.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int unsigned waits, input logic [DW-1:0] sdata, input logic serr,
                           input int unsigned hold);
        int unsigned e, acc, exp_acc, bad, tries;
        logic exp_to, exp_err, got_rsp;
        logic [DW-1:0] exp_rdata;
        logic [DW+1:0] snap;

        if (TO != 0 && waits >= TO) begin
            exp_to = 1'b1; exp_err = 1'b1; exp_rdata = '0; exp_acc = TO;
        end else begin
            exp_to = 1'b0; exp_err = serr; exp_rdata = (!wr && !serr) ? sdata : '0;
            exp_acc = waits + 1;
        end

        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = wr;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_wdata = wdata;
        tries = 0;
        while (!bus_if.cmd_ready && tries < 8) begin
            @(negedge PCLK);
            tries++;
        end
        check("accept_delay", 32'(tries), 32'd0);
        @(posedge PCLK);
        #1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'($urandom);
        bus_if.cmd_addr  = AW'($urandom);
        bus_if.cmd_wdata = DW'($urandom);

        e = 0; acc = 0; bad = 0; got_rsp = 1'b0;
        while (e < 64) begin
            @(negedge PCLK);
            if (bus_if.rsp_valid) begin
                got_rsp = 1'b1;
                break;
            end
            if (!bus_if.PSELx || bus_if.PADDR !== addr || bus_if.PWRITE !== wr ||
                (wr && bus_if.PWDATA !== wdata) || bus_if.PENABLE !== (e >= 1) ||
                bus_if.cmd_ready) bad++;
            if (bus_if.PENABLE) begin
                acc++;
                bus_if.PREADY  = (acc > waits);
                bus_if.PSLVERR = bus_if.PREADY ? serr : 1'($urandom);
                bus_if.PRDATA  = bus_if.PREADY ? sdata : DW'($urandom);
            end else begin
                bus_if.PREADY  = 1'($urandom);
                bus_if.PSLVERR = 1'($urandom);
                bus_if.PRDATA  = DW'($urandom);
            end
            @(posedge PCLK);
            e++;
        end
        check("rsp_seen", 32'(got_rsp), 32'd1);
        check("rsp_latency", 32'(e), 32'(1 + exp_acc));
        check("apb_protocol", 32'(bad), 32'd0);
        check("rsp_rdata", 32'(bus_if.rsp_rdata), 32'(exp_rdata));
        check("rsp_err", 32'(bus_if.rsp_err), 32'(exp_err));
        check("rsp_timeout", 32'(bus_if.rsp_timeout), 32'(exp_to));
        check("psel_idle", 32'({bus_if.PSELx, bus_if.PENABLE}), 32'd0);

        if (hold > 0) begin
            snap = {bus_if.rsp_rdata, bus_if.rsp_err, bus_if.rsp_timeout};
            bus_if.cmd_valid = 1'b1;
            bad = 0;
            for (int i = 0; i < int'(hold); i++) begin
                bus_if.PREADY  = 1'($urandom);
                bus_if.PSLVERR = 1'($urandom);
                bus_if.PRDATA  = DW'($urandom);
                @(posedge PCLK);
                @(negedge PCLK);
                if ({bus_if.rsp_rdata, bus_if.rsp_err, bus_if.rsp_timeout} !== snap ||
                    !bus_if.rsp_valid || bus_if.cmd_ready || bus_if.PSELx) bad++;
            end
            check("rsp_hold", 32'(bad), 32'd0);
        end

        bus_if.rsp_ready = 1'b1;
        @(posedge PCLK);
        #1;
        bus_if.rsp_ready = 1'b0;
        bus_if.cmd_valid = 1'b0;
        @(negedge PCLK);
        check("post_hs", 32'({bus_if.rsp_valid, bus_if.cmd_ready}), 32'b01);
    endtask

    task automatic reset_mid_access();
        int unsigned bad;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 4'h7;
        bus_if.cmd_wdata = 8'h00;
        bus_if.PREADY    = 1'b0;
        check("rst_pre_ready", 32'(bus_if.cmd_ready), 32'd1);
        @(posedge PCLK);
        #1;
        bus_if.cmd_valid = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("rst_in_access", 32'({bus_if.PSELx, bus_if.PENABLE}), 32'b11);
        PRESETn = 1'b0;
        @(posedge PCLK);
        #1;
        check("rst_outputs", all_outputs(), 32'd0);
        @(negedge PCLK);
        PRESETn          = 1'b1;
        bus_if.PREADY    = 1'b1;
        bus_if.PRDATA    = 8'hEE;
        bus_if.rsp_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            if (bus_if.rsp_valid || bus_if.PSELx) bad++;
        end
        check("rst_no_rsp", 32'(bad), 32'd0);
        check("rst_release_ready", 32'(bus_if.cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned r, w;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_wdata = '0;
        bus_if.rsp_ready = 1'b0;
        bus_if.PREADY    = 1'b0;
        bus_if.PRDATA    = '0;
        bus_if.PSLVERR   = 1'b0;

        repeat (3) @(posedge PCLK);
        #1;
        check("reset_outputs", all_outputs(), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        check("reset_release_ready", 32'(bus_if.cmd_ready), 32'd1);

        run_txn(1'b1, 4'h1, 8'hA5, 0, 8'h00, 1'b0, 0);    // zero-wait write
        run_txn(1'b0, 4'h2, 8'h00, 3, 8'h3C, 1'b0, 0);    // read, 3 wait states
        run_txn(1'b0, 4'hF, 8'h00, 0, 8'h99, 1'b1, 0);    // slave error
        run_txn(1'b0, 4'h4, 8'h00, 100, 8'h55, 1'b0, 0);  // stuck PREADY
        run_txn(1'b0, 4'h5, 8'h00, TO - 1, 8'h81, 1'b0, 0);
        run_txn(1'b1, 4'h6, 8'h5A, 2, 8'h00, 1'b0, 10);   // backpressure
        run_txn(1'b1, 4'h3, 8'hC3, 0, 8'h00, 1'b0, 0);
        reset_mid_access();

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            w = (r < 7) ? r % 4 : $urandom_range(TO - 2, TO + 4);
            run_txn(1'($urandom), AW'($urandom), DW'($urandom), w, DW'($urandom),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that turns a simple valid/ready command stream into AMBA APB setup/access transfers. It sits directly upstream of the UART APB slave and drives its PADDR/PSELx/PENABLE/PWRITE/PWDATA. It returns PRDATA/PSLVERR, plus a local timeout flag, on a valid/ready response stream. The command side is fed by the test sequencer or a host CPU shim.

## Interface
- ADDR_WIDTH, 4, APB address width; matches the slave.
- DATA_WIDTH, 8, APB data width (8/16/32).
- TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout.

Ports:
- PCLK  in  1  clock, sole clock domain.
- PRESETn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors.
- rsp_err  out  1  PSLVERR was sampled, or timeout occurred.
- rsp_timeout  out  1  transfer was aborted by timeout.
- PADDR  out  ADDR_WIDTH  APB address.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_WIDTH  slave read data.
- PSLVERR  in  1  slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE
  - cmd_ready = 1, and only in this state.
  - On cmd_valid: latch write/addr/wdata into PWRITE/PADDR/PWDATA, set PSELx = 1, PENABLE = 0, go to SETUP.
- SETUP
  - Lasts exactly one cycle.
  - Next state is ACCESS with PENABLE = 1; clear the timeout counter.
- ACCESS
  - Sample PREADY each cycle.
  - PREADY = 1: capture PRDATA (reads only, and only when PSLVERR = 0; otherwise rdata = 0). Capture PSLVERR into rsp_err, clear rsp_timeout, drop PSELx/PENABLE, go to RESP.
  - PREADY = 0: increment the counter. If TIMEOUT ≠ 0 and counter == TIMEOUT−1, abort: drop PSELx/PENABLE, rsp_err = 1, rsp_timeout = 1, rdata = 0, go to RESP.
- RESP
  - rsp_valid = 1. rsp_rdata/rsp_err/rsp_timeout are held stable until rsp_ready.
  - On rsp_ready: rsp_valid = 0, go to IDLE.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. They keep their last value in IDLE/RESP.
- PREADY and PSLVERR are ignored outside ACCESS. PSLVERR counts only when PREADY = 1.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
- Reset (PRESETn = 0 at an edge) takes priority in every state: go to IDLE and discard any in-flight response.
  - Reset values: cmd_ready = 0 during reset and 1 on the first cycle after release. Every other output is 0: rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PADDR, PSELx, PENABLE, PWRITE, PWDATA.

## Timing
- Command accepted at edge N: SETUP during cycle N+1, ACCESS from N+2.
- With zero wait states (PREADY = 1 in the first ACCESS cycle), rsp_valid rises at edge N+3.
- Each slave wait state adds one cycle.
- Back-to-back throughput with rsp_ready held high: one transfer per 4 cycles. The next cmd_ready rises one cycle after the response handshake.
- Timeout: ACCESS lasts at most TIMEOUT cycles, so rsp_valid appears at N+2+TIMEOUT.
- PSELx is low for at least one cycle between transfers. The SETUP→ACCESS rule is never violated.

## Structure
- Shared package apb_pkg holds:
  - state encoding localparams (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3);
  - the response flag bit positions shared with the UART slave side.
- Single flat module. The timeout counter is inline with no sub-module; it is too small to justify one.

## Test plan
- Write, zero-wait: write addr 0x1 data 0xA5 to a zero-wait slave → PSELx at N+1, PENABLE at N+2, PWDATA = 0xA5 stable, rsp_valid at N+3, rsp_err = 0, rsp_rdata = 0.
- Read with wait states: read addr 0x2 while the slave inserts 3 wait states then returns 0x3C → rsp_valid at N+6, rsp_rdata = 0x3C, and PADDR held at 0x2 for all 4 ACCESS cycles.
- Slave error: slave asserts PSLVERR with PREADY on a read of 0xF → rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
- Timeout: PREADY stuck at 0 with TIMEOUT = 16 → PSELx drops after 16 ACCESS cycles, rsp_valid at N+18, rsp_err = 1, rsp_timeout = 1.
- Response backpressure: hold rsp_ready = 0 for 10 cycles with a second cmd_valid pending → response stable, cmd_ready = 0, PSELx = 0 throughout. The second command is accepted one cycle after the handshake.
- Reset mid-transfer: assert PRESETn = 0 during ACCESS → at the next edge all outputs are 0 and no rsp_valid appears. After release, cmd_ready = 1.
